// File: rtl/tbus_arbiter_pkg.sv
// Shared types and encodings for the tbus two-requester arbiter.
package tbus_arbiter_pkg;

    // Datapath widths (index / data / mask are all result-width words)
    localparam int RESULT_W      = 64;
    localparam int TBUS_OPTYPE_W = 2;

    typedef logic [RESULT_W-1:0]      result_t;
    typedef logic [TBUS_OPTYPE_W-1:0] tbus_optype_t;

    localparam tbus_optype_t TBUS_READ  = 2'd0;
    localparam tbus_optype_t TBUS_WRITE = 2'd1;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        ARB_IDLE        = 2'd0,
        ARB_GRANT       = 2'd1,
        ARB_OUTSTANDING = 2'd2
    } arb_state_e;

    // Requester IDs
    localparam logic ARB_REQ_IFU = 1'b0;
    localparam logic ARB_REQ_LSU = 1'b1;

    // One requester's tbus payload
    typedef struct packed {
        result_t      index;
        result_t      write_data;
        result_t      write_mask;
        tbus_optype_t optype;
    } tbus_req_t;

endpackage

// File: rtl/tbus_rr_pick.sv
// Combinational 2-way round-robin pick: on a tie the requester that did
// not win last time is chosen.
module tbus_rr_pick
    import tbus_arbiter_pkg::*;
(
    input  logic [1:0] req_valid,
    input  logic       last_grant,
    output logic       winner,
    output logic       any
);

    // Single requester wins outright; tie goes to the one not granted last
    always_comb begin
        any = |req_valid;
        if (req_valid == 2'b11)
            winner = ~last_grant;
        else if (req_valid[1])
            winner = ARB_REQ_LSU;
        else
            winner = ARB_REQ_IFU;
    end

endmodule

// File: rtl/tbus_arbiter.sv
// Shares the tbus channel between the IFU (requester 0) and the LSU
// (requester 1). One transaction at a time, held from index handshake to
// operation_done, with LSU flush handling and a hang watchdog.
module tbus_arbiter
    import tbus_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [1:0]               req_valid,
    output logic [1:0]               req_ready,
    input  logic [RESULT_W-1:0]      req_index_0,
    input  logic [RESULT_W-1:0]      req_index_1,
    input  logic [RESULT_W-1:0]      req_write_data_0,
    input  logic [RESULT_W-1:0]      req_write_data_1,
    input  logic [RESULT_W-1:0]      req_write_mask_0,
    input  logic [RESULT_W-1:0]      req_write_mask_1,
    input  logic [TBUS_OPTYPE_W-1:0] req_optype_0,
    input  logic [TBUS_OPTYPE_W-1:0] req_optype_1,
    output logic [1:0]               resp_done,
    output logic [RESULT_W-1:0]      resp_read_data,
    input  logic                     lsu_flush,
    output logic                     tbus_index_valid,
    input  logic                     tbus_index_ready,
    output logic [RESULT_W-1:0]      tbus_index,
    output logic [RESULT_W-1:0]      tbus_write_data,
    output logic [RESULT_W-1:0]      tbus_write_mask,
    output logic [TBUS_OPTYPE_W-1:0] tbus_operation_type,
    input  logic [RESULT_W-1:0]      tbus_read_data,
    input  logic                     tbus_operation_done,
    output logic                     timeout_err
);

    arb_state_e  state_q;
    logic        grant_id_q;
    logic        last_grant_q;
    logic        drop_q;
    logic [15:0] wd_cnt_q;
    logic        timeout_q;

    logic        pick_winner;
    logic        pick_any;
    tbus_req_t   req0, req1, payload;
    logic        in_grant, in_out;
    logic        flush_hit;
    logic        fire;
    logic        done_ok;

    tbus_rr_pick u_pick (
        .req_valid  (req_valid),
        .last_grant (last_grant_q),
        .winner     (pick_winner),
        .any        (pick_any)
    );

    assign req0 = '{index: req_index_0, write_data: req_write_data_0,
                    write_mask: req_write_mask_0, optype: req_optype_0};
    assign req1 = '{index: req_index_1, write_data: req_write_data_1,
                    write_mask: req_write_mask_1, optype: req_optype_1};

    // Grant-side decode: payload mux, handshake and completion routing
    always_comb begin
        in_grant  = (state_q == ARB_GRANT);
        in_out    = (state_q == ARB_OUTSTANDING);
        // A flush only ever targets the LSU's transaction
        flush_hit = lsu_flush && (grant_id_q == ARB_REQ_LSU);
        fire      = in_grant && !flush_hit && tbus_index_ready;
        payload   = '0;
        if (in_grant)
            payload = (grant_id_q == ARB_REQ_LSU) ? req1 : req0;
        // A flush landing in the same cycle as done is treated as already
        // having killed the transaction, so its response is dropped too.
        done_ok   = tbus_operation_done &&
                    ((in_grant && fire) || (in_out && !drop_q && !flush_hit));
        req_ready = '0;
        req_ready[grant_id_q] = fire;
        resp_done = '0;
        resp_done[grant_id_q] = done_ok;
    end

    assign tbus_index_valid    = in_grant && !flush_hit;
    assign tbus_index          = payload.index;
    assign tbus_write_data     = payload.write_data;
    assign tbus_write_mask     = payload.write_mask;
    assign tbus_operation_type = payload.optype;
    assign resp_read_data      = tbus_read_data;
    assign timeout_err         = timeout_q;

    // Arbitration FSM with grant owner, round-robin history and drop flag
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ARB_IDLE;
            grant_id_q   <= ARB_REQ_IFU;
            last_grant_q <= ARB_REQ_LSU;
            drop_q       <= 1'b0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (pick_any) begin
                        grant_id_q <= pick_winner;
                        state_q    <= ARB_GRANT;
                    end
                end
                ARB_GRANT: begin
                    if (flush_hit) begin
                        state_q <= ARB_IDLE;
                    end else if (fire) begin
                        last_grant_q <= grant_id_q;
                        drop_q       <= 1'b0;
                        state_q      <= tbus_operation_done ? ARB_IDLE : ARB_OUTSTANDING;
                    end
                end
                ARB_OUTSTANDING: begin
                    if (tbus_operation_done) begin
                        drop_q  <= 1'b0;
                        state_q <= ARB_IDLE;
                    end else if (flush_hit) begin
                        drop_q  <= 1'b1;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    // Watchdog: count OUTSTANDING cycles, raise a sticky flag at the limit
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (in_out && !tbus_operation_done) begin
                if (wd_cnt_q != 16'hFFFF)
                    wd_cnt_q <= wd_cnt_q + 16'd1;
            end else begin
                wd_cnt_q <= '0;
            end
            // The count becomes TIMEOUT_CYCLES this edge, flag rises with it
            if (in_out && (int'(wd_cnt_q) + 1 >= TIMEOUT_CYCLES))
                timeout_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_tbus_arbiter.sv
// Directed bench for tbus_arbiter: single read, alternating grants, stall,
// LSU flush in both grant phases, same-cycle done, watchdog and reset.
module tb_tbus_arbiter;
    import tbus_arbiter_pkg::*;

    logic                     clock;
    logic                     reset_n;
    logic [1:0]               req_valid;
    logic [1:0]               req_ready;
    logic [RESULT_W-1:0]      req_index_0, req_index_1;
    logic [RESULT_W-1:0]      req_write_data_0, req_write_data_1;
    logic [RESULT_W-1:0]      req_write_mask_0, req_write_mask_1;
    logic [TBUS_OPTYPE_W-1:0] req_optype_0, req_optype_1;
    logic [1:0]               resp_done;
    logic [RESULT_W-1:0]      resp_read_data;
    logic                     lsu_flush;
    logic                     tbus_index_valid;
    logic                     tbus_index_ready;
    logic [RESULT_W-1:0]      tbus_index, tbus_write_data, tbus_write_mask;
    logic [TBUS_OPTYPE_W-1:0] tbus_operation_type;
    logic [RESULT_W-1:0]      tbus_read_data;
    logic                     tbus_operation_done;
    logic                     timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    tbus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .req_valid           (req_valid),
        .req_ready           (req_ready),
        .req_index_0         (req_index_0),
        .req_index_1         (req_index_1),
        .req_write_data_0    (req_write_data_0),
        .req_write_data_1    (req_write_data_1),
        .req_write_mask_0    (req_write_mask_0),
        .req_write_mask_1    (req_write_mask_1),
        .req_optype_0        (req_optype_0),
        .req_optype_1        (req_optype_1),
        .resp_done           (resp_done),
        .resp_read_data      (resp_read_data),
        .lsu_flush           (lsu_flush),
        .tbus_index_valid    (tbus_index_valid),
        .tbus_index_ready    (tbus_index_ready),
        .tbus_index          (tbus_index),
        .tbus_write_data     (tbus_write_data),
        .tbus_write_mask     (tbus_write_mask),
        .tbus_operation_type (tbus_operation_type),
        .tbus_read_data      (tbus_read_data),
        .tbus_operation_done (tbus_operation_done),
        .timeout_err         (timeout_err)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Start of a new cycle: just past the rising edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        req_valid = '0; lsu_flush = 0; tbus_index_ready = 0; tbus_operation_done = 0;
        req_index_0 = '0; req_index_1 = '0; req_write_data_0 = '0; req_write_data_1 = '0;
        req_write_mask_0 = '0; req_write_mask_1 = '0;
        req_optype_0 = TBUS_READ; req_optype_1 = TBUS_READ; tbus_read_data = '0;
    endtask

    task automatic reset_dut();
        clear_inputs();
        reset_n = 0;
        tick();
        reset_n = 1;
    endtask

    task automatic check_all_zero(input string tag);
        n_checks++;
        if ({req_ready, resp_done, resp_read_data, tbus_index_valid, tbus_index,
             tbus_write_data, tbus_write_mask, tbus_operation_type, timeout_err} !== '0) begin
            n_fail++;
            $display("FAIL %s: outputs not all zero (ready=%b done=%b valid=%b idx=%h to=%b)",
                     tag, req_ready, resp_done, tbus_index_valid, tbus_index, timeout_err);
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        reset_n = 0;
        #2;
        check_all_zero("reset_outputs");
        tick();
        reset_n = 1;
    endtask

    task automatic test_single_read();
        tick(); req_valid = 2'b01; req_index_0 = 64'h8000_1000; req_optype_0 = TBUS_READ; #1;
        n_checks++; if (tbus_index_valid !== 1'b0) begin n_fail++; $display("FAIL single_c1_valid: got %b want 0", tbus_index_valid); end
        tick(); tbus_index_ready = 1; #1;
        n_checks++; if (tbus_index_valid !== 1'b1) begin n_fail++; $display("FAIL single_c2_valid: got %b want 1", tbus_index_valid); end
        n_checks++; if (tbus_index !== 64'h8000_1000) begin n_fail++; $display("FAIL single_c2_index: got %h want 80001000", tbus_index); end
        n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL single_c2_ready: got %b want 01", req_ready); end
        tick(); req_valid = 0; tbus_index_ready = 0; #1;
        n_checks++; if ({tbus_index_valid, tbus_index} !== '0) begin n_fail++; $display("FAIL single_c3_idle_bus: valid=%b idx=%h want 0", tbus_index_valid, tbus_index); end
        n_checks++; if (resp_done !== 2'b00) begin n_fail++; $display("FAIL single_c3_done: got %b want 00", resp_done); end
        tick(); tbus_operation_done = 1; tbus_read_data = 64'h1122_3344_5566_7788; #1;
        n_checks++; if (resp_done !== 2'b01) begin n_fail++; $display("FAIL single_c4_done: got %b want 01", resp_done); end
        n_checks++; if (resp_read_data !== 64'h1122_3344_5566_7788) begin n_fail++; $display("FAIL single_c4_rdata: got %h want 1122334455667788", resp_read_data); end
        tick(); tbus_operation_done = 0; #1;
        n_checks++; if (resp_done !== 2'b00) begin n_fail++; $display("FAIL single_c5_done: got %b want 00", resp_done); end
    endtask

    task automatic test_back_to_back();
        logic g;
        reset_dut();
        req_index_0 = 64'hA0; req_index_1 = 64'hB1;
        for (int k = 0; k < 4; k++) begin
            g = k[0];
            tick(); req_valid = 2'b11; tbus_index_ready = 1; tbus_operation_done = 0; #1;
            n_checks++; if ({tbus_index_valid, req_ready} !== 3'b000) begin n_fail++; $display("FAIL b2b_idle_%0d: valid=%b ready=%b want 0", k, tbus_index_valid, req_ready); end
            tick(); #1;
            n_checks++; if (tbus_index !== (g ? 64'hB1 : 64'hA0)) begin n_fail++; $display("FAIL b2b_grant_%0d: index=%h want grant %0d", k, tbus_index, g); end
            n_checks++; if (req_ready !== (g ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL b2b_ready_%0d: got %b want grant %0d", k, req_ready, g); end
            tick(); tbus_operation_done = 1; tbus_read_data = 64'h100 + 64'(k); #1;
            n_checks++; if (resp_done !== (g ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL b2b_done_%0d: got %b want grant %0d", k, resp_done, g); end
            n_checks++; if (resp_read_data !== 64'h100 + 64'(k)) begin n_fail++; $display("FAIL b2b_rdata_%0d: got %h want %h", k, resp_read_data, 64'h100 + 64'(k)); end
        end
        tick(); req_valid = 0; tbus_index_ready = 0; tbus_operation_done = 0; #1;
    endtask

    task automatic test_stall();
        tick(); req_valid = 2'b10; req_index_1 = 64'h2000; req_write_data_1 = 64'hAB00;
        req_write_mask_1 = 64'hFF00; req_optype_1 = TBUS_WRITE; tbus_index_ready = 0; #1;
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            n_checks++;
            if ({tbus_index_valid, tbus_index, tbus_write_data, tbus_write_mask, tbus_operation_type, req_ready} !==
                {1'b1, 64'h2000, 64'hAB00, 64'hFF00, TBUS_WRITE, 2'b00}) begin
                n_fail++;
                $display("FAIL stall_hold_%0d: valid=%b idx=%h wd=%h wm=%h op=%0d ready=%b want 1/2000/ab00/ff00/1/00",
                         i, tbus_index_valid, tbus_index, tbus_write_data, tbus_write_mask, tbus_operation_type, req_ready);
            end
        end
        tick(); tbus_index_ready = 1; #1;
        n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL stall_ready: got %b want 10", req_ready); end
        tick(); req_valid = 0; tbus_index_ready = 0; tbus_operation_done = 1; #1;
        n_checks++; if (resp_done !== 2'b10) begin n_fail++; $display("FAIL stall_done: got %b want 10", resp_done); end
        tick(); tbus_operation_done = 0; #1;
    endtask

    task automatic test_flush_outstanding();
        tick(); req_valid = 2'b10; req_index_1 = 64'h3000; req_optype_1 = TBUS_READ; #1;
        tick(); tbus_index_ready = 1; #1;
        n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL flush_out_fire: got %b want 10", req_ready); end
        tick(); req_valid = 0; tbus_index_ready = 0; lsu_flush = 1; #1;
        tick(); lsu_flush = 0; #1;
        tick(); tbus_operation_done = 1; #1;
        n_checks++; if (resp_done !== 2'b00) begin n_fail++; $display("FAIL flush_out_drop: got %b want 00", resp_done); end
        tick(); tbus_operation_done = 0; req_valid = 2'b01; req_index_0 = 64'h4000; #1;
        n_checks++; if (tbus_index_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_idle: got %b want 0", tbus_index_valid); end
        tick(); tbus_index_ready = 1; #1;
        n_checks++; if ({tbus_index_valid, tbus_index, req_ready} !== {1'b1, 64'h4000, 2'b01}) begin n_fail++; $display("FAIL flush_out_req0: valid=%b idx=%h ready=%b want 1/4000/01", tbus_index_valid, tbus_index, req_ready); end
        tick(); req_valid = 0; tbus_index_ready = 0; tbus_operation_done = 1; #1;
        n_checks++; if (resp_done !== 2'b01) begin n_fail++; $display("FAIL flush_out_after: got %b want 01", resp_done); end
        tick(); tbus_operation_done = 0; #1;
    endtask

    task automatic test_flush_grant();
        tick(); req_valid = 2'b10; req_index_1 = 64'h5000; #1;
        tick(); lsu_flush = 1; tbus_index_ready = 1; #1;
        n_checks++; if ({tbus_index_valid, req_ready} !== 3'b000) begin n_fail++; $display("FAIL flush_grant_kill: valid=%b ready=%b want 0/00", tbus_index_valid, req_ready); end
        tick(); lsu_flush = 0; tbus_index_ready = 0; #1;
        n_checks++; if ({tbus_index_valid, resp_done} !== 3'b000) begin n_fail++; $display("FAIL flush_grant_idle: valid=%b done=%b want 0/00", tbus_index_valid, resp_done); end
        tick(); tbus_index_ready = 1; tbus_operation_done = 1; tbus_read_data = 64'h55; #1;
        n_checks++; if ({tbus_index_valid, req_ready, resp_done} !== 5'b1_10_10) begin n_fail++; $display("FAIL flush_grant_regrant: valid=%b ready=%b done=%b want 1/10/10", tbus_index_valid, req_ready, resp_done); end
        tick(); req_valid = 0; tbus_index_ready = 0; #1;
        n_checks++; if (resp_done !== 2'b00) begin n_fail++; $display("FAIL flush_grant_noecho: got %b want 00", resp_done); end
        tick(); tbus_operation_done = 0; #1;
    endtask

    task automatic test_same_cycle();
        tick(); req_valid = 2'b01; req_index_0 = 64'h6000; lsu_flush = 1; #1;
        tick(); tbus_index_ready = 1; tbus_operation_done = 1; #1;
        n_checks++; if ({tbus_index_valid, req_ready, resp_done} !== 5'b1_01_01) begin n_fail++; $display("FAIL same_cycle_done: valid=%b ready=%b done=%b want 1/01/01", tbus_index_valid, req_ready, resp_done); end
        tick(); req_valid = 0; tbus_index_ready = 0; lsu_flush = 0; #1;
        n_checks++; if ({tbus_index_valid, resp_done} !== 3'b000) begin n_fail++; $display("FAIL same_cycle_idle: valid=%b done=%b want 0/00", tbus_index_valid, resp_done); end
        tick(); tbus_operation_done = 0; #1;
    endtask

    task automatic test_timeout();
        tick(); req_valid = 2'b01; req_index_0 = 64'h7000; #1;
        tick(); tbus_index_ready = 1; #1;
        n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL timeout_fire: got %b want 01", req_ready); end
        for (int k = 1; k <= 12; k++) begin
            tick(); req_valid = 0; tbus_index_ready = 0; #1;
            n_checks++; if (timeout_err !== (k >= 9)) begin n_fail++; $display("FAIL timeout_out_%0d: got %b want %b", k, timeout_err, k >= 9); end
        end
        clear_inputs();
        reset_n = 0;
        #1;
        check_all_zero("timeout_reset");
        tick(); reset_n = 1;
        tick(); tbus_operation_done = 1; #1;
        n_checks++; if ({resp_done, timeout_err} !== 3'b000) begin n_fail++; $display("FAIL idle_done_ignored: done=%b to=%b want 00/0", resp_done, timeout_err); end
        tick(); tbus_operation_done = 0; #1;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_back_to_back();
        test_stall();
        test_flush_outstanding();
        test_flush_grant();
        test_same_cycle();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
